booth_csa_accum: RTL and testbench
==================================

Name: booth_csa_accum

Overview:
- Sequential radix-4 Booth partial-product generator and carry-save accumulator for the 32x32 multiplier datapath.
- Sits directly upstream of the 64-bit final ripple adder.
- Accepts one operand pair, processes one Booth digit per cycle through a 3:2 compressor, and emits redundant sum/carry vectors. Their plain binary sum mod 2^(2*WIDTH) is the product.
- Handshake on both sides.

Parameters:
WIDTH, 32, operand width; even, >=4. Output width is 2*WIDTH. Digit count NDIG = WIDTH/2+1.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
a_i  input  WIDTH  multiplicand
b_i  input  WIDTH  multiplier
signed_i  input  1  1: two's-complement operands; 0: unsigned
out_valid  output  1  sum_o/carry_o hold a finished result
out_ready  input  1  downstream adder stage takes the result
sum_o  output  2*WIDTH  CSA sum vector
carry_o  output  2*WIDTH  CSA carry vector, already left-aligned (bit 0 always 0)

Behaviour:
- Reset (async assert, sync-release use):
  - State goes to IDLE; sum_o=0, carry_o=0, out_valid=0, digit counter=0.
  - in_ready=1 once state is IDLE.
- States IDLE, RUN, DONE:
  - in_ready = (IDLE) or (DONE and out_ready). out_valid = (DONE).
- Accept (in_valid and in_ready at edge):
  - Extend the multiplicand to 2*WIDTH and the multiplier to WIDTH+2 bits. Both use sign extension if signed_i=1, zero extension otherwise. Latch the extended values and signed_i.
  - Clear sum/carry and set cnt=0. Go to RUN.
  - in_valid while not in_ready is ignored; latched operands are never disturbed.
- RUN, each edge: process digit d=cnt.
  - Recode bits y[2d+1], y[2d], y[2d-1] (y[-1]=0) to a digit in {-2,-1,0,+1,+2}.
  - pp = (digit * x_ext) << 2d, truncated to 2*WIDTH bits. The negation is a full two's complement computed in pp, with no hot-one injection.
  - sum' = sum ^ carry ^ pp.
  - carry' = (majority(sum,carry,pp)) << 1, truncated.
  - cnt+1. On the edge processing cnt==NDIG-1, go to DONE.
- Latency:
  - Accept at edge k means digits are processed at edges k+1..k+NDIG.
  - out_valid is high after edge k+NDIG, i.e. 17 cycles for WIDTH=32.
- DONE:
  - sum_o/carry_o and out_valid are held stable while out_ready=0.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid drops the next cycle.
  - out_ready=1 and in_valid=1: hand off and accept new operands on the same edge, going to RUN (back-to-back, no bubble cycle in IDLE).
- Outputs:
  - sum_o/carry_o update only during RUN/accept. They are not required to be meaningful unless out_valid=1.
- Arithmetic:
  - All arithmetic is modulo 2^(2*WIDTH); overflow out of the MSB is discarded.
  - Invariant: (sum_o + carry_o) mod 2^(2W) = a*b for unsigned, or the 2W-bit two's-complement product for signed.
- Reset mid-RUN or mid-DONE:
  - The operation is abandoned and no result is emitted.
  - Outputs return to reset values immediately (asynchronously).
- signed_i changing during RUN has no effect; only the value latched at accept is used.

Test Plan:
1. Unsigned 0xFFFFFFFF x 0xFFFFFFFF, out_ready=1 -> out_valid exactly 17 cycles after accept. sum_o+carry_o = 0xFFFFFFFE00000001; out_valid high 1 cycle; in_ready returns.
2. Signed cases:
   - -1 x -1 -> 0x0000000000000001.
   - 0x80000000 x 0x80000000 -> 0x4000000000000000.
   - 0x80000000 x 0x7FFFFFFF -> 0xC000000080000000.
   - Unsigned 0x80000000 x 0x80000000 -> 0x4000000000000000; unsigned 0x80000000 x 0xFFFFFFFF -> 0x7FFFFFFF80000000.
3. Backpressure:
   - Result ready with out_ready=0 for 5 cycles -> sum_o/carry_o/out_valid constant; in_ready=0; in_valid pulses ignored.
   - Then out_ready=1 with in_valid=1 (3 x 5) -> new op accepted that edge; next result sum+carry = 15 after 17 cycles.
4. in_valid asserted every cycle during RUN with changing a_i/b_i -> result matches only the operands latched at accept (e.g. 0x1234 x 0x5678 = 0x6260060).
5. Assert rst_n=0 asynchronously at the 8th RUN cycle -> sum_o=carry_o=0, out_valid=0 immediately, no result emitted. After release, in_ready=1; 7 x 0 -> sum+carry = 0.
6. Random signed/unsigned pairs (>=1000), out_ready randomly toggled -> every result checked against reference product via sum_o+carry_o mod 2^64; carry_o[0] always 0.

Source files
------------

// File: rtl/booth_csa_accum.sv
// Sequential radix-4 Booth multiplier front end: one Booth digit per cycle is folded into a
// carry-save pair through a 3:2 compressor; (sum_o + carry_o) mod 2^(2*WIDTH) is the product.
module booth_csa_accum #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [2*WIDTH-1:0] carry_o
);

  localparam int unsigned OW   = 2 * WIDTH;
  localparam int unsigned NDIG = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   x_q, x_d;
  logic [WIDTH+1:0] y_q, y_d;
  logic [OW-1:0]   sum_q, sum_d;
  logic [OW-1:0]   carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic [WIDTH+2:0] y_pad;
  logic [2:0]      trip;
  logic [OW-1:0]   pp_base, pp, maj;

  // Booth digit window y[2d+1:2d-1], with y[-1] supplied by the padding zero.
  always_comb begin
    y_pad = {y_q, 1'b0};
    trip  = 3'b000;
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (cnt_q == CW'(d)) trip = y_pad[2*d +: 3];
    end
  end

  always_comb begin
    pp_base = '0;
    case (trip)
      3'b001, 3'b010: pp_base = x_q;
      3'b011:         pp_base = x_q << 1;
      3'b100:         pp_base = -(x_q << 1);
      3'b101, 3'b110: pp_base = -x_q;
      default:        pp_base = '0;
    endcase
    pp  = pp_base << {cnt_q, 1'b0};
    maj = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      StRun: begin
        sum_d   = sum_q ^ carry_q ^ pp;
        carry_d = maj << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: ;
    endcase

    // Accept overrides the DONE hand-off so back-to-back operations skip IDLE.
    if (accept) begin
      x_d     = signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
      y_d     = {{2{signed_i & b_i[WIDTH-1]}}, b_i};
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign sum_o     = sum_q;
  assign carry_o   = carry_q;

endmodule

// File: tb/tb_booth_csa_accum.sv
// Directed and randomized bench for booth_csa_accum; products are checked against a plain
// 64-bit arithmetic reference, along with latency, handshake and reset behaviour.
module tb_booth_csa_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        signed_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum_o;
  logic [63:0] carry_o;

  int checks = 0;
  int errors = 0;

  booth_csa_accum #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .signed_i  (signed_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .carry_o   (carry_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands, wait (bounded) for in_ready, and return on the edge that accepts them.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    a_i = a; b_i = b; signed_i = s; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid appears.
  task automatic wait_result(input string tag, input logic [63:0] exp);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd17);
    chk({tag, "_product"}, sum_o + carry_o, exp);
    chk({tag, "_carry0"}, 64'(carry_o[0]), 64'd0);
  endtask

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  logic        ss [5];
  logic [63:0] se [5];
  logic [63:0] snap_s, snap_c;
  logic [31:0] ra, rb;
  logic        rs;
  int          seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; signed_i = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_sum", sum_o, 64'd0);
    chk("rst_carry", carry_o, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: unsigned max x max, single-cycle result with out_ready held high
    out_ready = 1'b1;
    accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("t1_run_in_ready", 64'(in_ready), 64'd0);
    wait_result("t1", 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    chk("t1_valid_drop", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);

    // 2: signed / unsigned corner operands
    sa = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    sb = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    ss = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    se = '{64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000,
           64'h4000_0000_0000_0000, 64'h7FFF_FFFF_8000_0000};
    for (int i = 0; i < 5; i++) begin
      accept_op(sa[i], sb[i], ss[i]);
      wait_result($sformatf("t2_%0d", i), se[i]);
      @(posedge clk); #1;
    end

    // 3: backpressure, then back-to-back accept on the hand-off edge
    out_ready = 1'b0;
    accept_op(32'h1111, 32'h2222, 1'b0);
    wait_result("t3a", 64'h1111 * 64'h2222);
    snap_s = sum_o; snap_c = carry_o;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a_i = $urandom; b_i = $urandom;
      chk("t3_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
      chk("t3_hold_sum", sum_o, snap_s);
      chk("t3_hold_carry", carry_o, snap_c);
    end
    a_i = 32'd3; b_i = 32'd5; signed_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t3_b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_b2b_running", 64'(out_valid), 64'd0);
    wait_result("t3b", 64'd15);
    @(posedge clk); #1;

    // 4: operand changes while busy must not disturb the latched pair
    accept_op(32'h1234, 32'h5678, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !out_valid; i++) begin
      a_i = $urandom; b_i = $urandom; signed_i = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_product", sum_o + carry_o, 64'h0626_0060);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // 5: asynchronous reset in the 8th RUN cycle
    accept_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sum", sum_o, 64'd0);
    chk("t5_carry", carry_o, 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("t5_no_result", 64'(seen), 64'd0);
    accept_op(32'd7, 32'd0, 1'b0);
    wait_result("t5b", 64'd0);
    @(posedge clk); #1;

    // 6: random operands with random stalls and random back-to-back hand-offs
    ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
    for (int i = 0; i < 1000; i++) begin
      accept_op(ra, rb, rs);
      out_ready = $urandom_range(0, 1);
      wait_result("t6", ref_mul(ra, rb, rs));
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("t6_hold_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: begin ra = 32'h8000_0000; end
        1: begin rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
        chk("t6_idle_drop", 64'(out_valid), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
